// File: rtl/dut_txn_master_if.sv
// Bus bundle for dut_txn_master: operand/result streams plus the DUT write/read port.
// The master modport is the transaction master's view; slave is the environment's view.
interface dut_txn_master_if #(
  parameter int DW = 8,
  parameter int AW = 3
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_a;
  logic [DW-1:0] in_b;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_y;
  logic          out_timeout;
  logic [AW-1:0] write_address;
  logic [DW-1:0] write_data;
  logic          write_en;
  logic          write_rdy;
  logic [AW-1:0] read_address;
  logic          read_en;
  logic [DW-1:0] read_data;
  logic          read_rdy;
  logic          busy;
  logic [15:0]   txn_count;
  logic [15:0]   timeout_count;

  modport master (
    input  in_valid, in_a, in_b, out_ready, write_rdy, read_data, read_rdy,
    output in_ready, out_valid, out_y, out_timeout, write_address, write_data,
           write_en, read_address, read_en, busy, txn_count, timeout_count
  );

  modport slave (
    output in_valid, in_a, in_b, out_ready, write_rdy, read_data, read_rdy,
    input  in_ready, out_valid, out_y, out_timeout, write_address, write_data,
           write_en, read_address, read_en, busy, txn_count, timeout_count
  );
endinterface

// File: rtl/dut_txn_master.sv
// Bus master for the A|B merge DUT: write A, write B, poll status, pop Y, present result.
// Optional handshake/timeout statistics counters enabled by DUT_TXN_MASTER_STATS_EN.
module dut_txn_master #(
  parameter int DW         = 8,
  parameter int AW         = 3,
  parameter int ADDR_A     = 0,
  parameter int ADDR_B     = 5,
  parameter int ADDR_STAT  = 2,
  parameter int ADDR_Y     = 3,
  parameter int POLL_LIMIT = 300
) (
  input logic              CLK,
  input logic              RST,
  dut_txn_master_if.master bus
);
  localparam int PCW = $clog2(POLL_LIMIT + 1);
  localparam logic [PCW-1:0] PLIM = PCW'(POLL_LIMIT);

  typedef enum logic [2:0] {S_IDLE, S_WR_A, S_WR_B, S_POLL, S_RD_Y, S_OUT} state_t;

  state_t         state_q, state_d;
  logic [DW-1:0]  a_q, a_d, b_q, b_d, y_q, y_d;
  logic           to_q, to_d;
  logic [PCW-1:0] poll_cnt_q, poll_cnt_d;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      y_q        <= '0;
      to_q       <= 1'b0;
      poll_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      y_q        <= y_d;
      to_q       <= to_d;
      poll_cnt_q <= poll_cnt_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    a_d               = a_q;
    b_d               = b_q;
    y_d               = y_q;
    to_d              = to_q;
    poll_cnt_d        = poll_cnt_q;
    bus.in_ready      = 1'b0;
    bus.out_valid     = 1'b0;
    bus.write_en      = 1'b0;
    bus.write_address = '0;
    bus.write_data    = '0;
    bus.read_en       = 1'b0;
    bus.read_address  = '0;
    unique case (state_q)
      S_IDLE: begin
        bus.in_ready = !RST;
        if (bus.in_valid && !RST) begin
          a_d        = bus.in_a;
          b_d        = bus.in_b;
          y_d        = '0;
          to_d       = 1'b0;
          poll_cnt_d = '0;
          state_d    = S_WR_A;
        end
      end
      S_WR_A: begin
        bus.write_en      = 1'b1;
        bus.write_address = AW'(ADDR_A);
        bus.write_data    = a_q;
        if (bus.write_rdy) state_d = S_WR_B;
      end
      S_WR_B: begin
        bus.write_en      = 1'b1;
        bus.write_address = AW'(ADDR_B);
        bus.write_data    = b_q;
        if (bus.write_rdy) state_d = S_POLL;
      end
      S_POLL: begin
        bus.read_address = AW'(ADDR_STAT);
        // Only cycles where the DUT actually answers count toward the limit.
        if (bus.read_rdy) begin
          if (bus.read_data[0]) begin
            state_d = S_RD_Y;
          end else begin
            if (poll_cnt_q < PLIM) poll_cnt_d = poll_cnt_q + 1'b1;
            if (poll_cnt_q >= PLIM - 1'b1) begin
              y_d     = '0;
              to_d    = 1'b1;
              state_d = S_OUT;
            end
          end
        end
      end
      S_RD_Y: begin
        bus.read_address = AW'(ADDR_Y);
        // Strobe only on the completing cycle so the DUT pops exactly once.
        bus.read_en      = bus.read_rdy;
        if (bus.read_rdy) begin
          y_d     = bus.read_data;
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.out_y       = y_q;
  assign bus.out_timeout = to_q;
  assign bus.busy        = (state_q != S_IDLE);

`ifdef DUT_TXN_MASTER_STATS_EN
  logic [15:0] txn_cnt_q, to_cnt_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      txn_cnt_q <= '0;
      to_cnt_q  <= '0;
    end else if (bus.out_valid && bus.out_ready) begin
      txn_cnt_q <= txn_cnt_q + 16'd1;
      if (to_q) to_cnt_q <= to_cnt_q + 16'd1;
    end
  end

  assign bus.txn_count     = txn_cnt_q;
  assign bus.timeout_count = to_cnt_q;
`else
  assign bus.txn_count     = '0;
  assign bus.timeout_count = '0;
`endif
endmodule

// File: tb/tb_dut_txn_master.sv
// Directed bench for dut_txn_master with a behavioural A|B DUT stub and a transaction scoreboard.
module tb_dut_txn_master;
  localparam int DW = 8;
  localparam int AW = 3;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  dut_txn_master_if #(.DW(DW), .AW(AW)) bus ();
  dut_txn_master #(.DW(DW), .AW(AW)) dut (.CLK(CLK), .RST(RST), .bus(bus));

  int errs = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // DUT stub: A and B registers, Y = A|B available once both written, popped by read_en at addr 3.
  logic [7:0] sa, sb;
  logic sav, sbv;
  logic stuck = 1'b0;
  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      sa <= '0; sb <= '0; sav <= 1'b0; sbv <= 1'b0;
    end else begin
      if (bus.write_en && bus.write_rdy) begin
        if (bus.write_address == 3'd0) begin sa <= bus.write_data; sav <= 1'b1; end
        if (bus.write_address == 3'd5) begin sb <= bus.write_data; sbv <= 1'b1; end
      end
      if (bus.read_en && bus.read_rdy && bus.read_address == 3'd3) begin
        sav <= 1'b0; sbv <= 1'b0;
      end
    end
  end
  assign bus.read_data = (bus.read_address == 3'd2) ? {7'b0, sav && sbv && !stuck} :
                         (bus.read_address == 3'd3) ? (sa | sb) : 8'h00;

  // Scoreboard: expected results, expected write sequence, poll sample count, handshake counts.
  typedef struct packed { logic [7:0] y; logic to; } exp_t;
  exp_t oq[$];
  logic [10:0] wq[$];
  int stat_cnt = 0, acc_cyc = 0, cyc = 0, txn_m = 0, to_m = 0;
  logic prev_ov = 1'b0, prev_or = 1'b0, prev_to = 1'b0;
  logic [7:0] prev_y = '0;
  logic min_lat = 1'b0;

  always @(negedge CLK) begin
    exp_t e;
    cyc++;
    if (RST) begin
      oq.delete(); wq.delete();
      stat_cnt = 0; txn_m = 0; to_m = 0; prev_ov = 1'b0;
    end else begin
`ifdef DUT_TXN_MASTER_STATS_EN
      chk("txn_count", 32'(bus.txn_count), 32'(txn_m[15:0]));
      chk("timeout_count", 32'(bus.timeout_count), 32'(to_m[15:0]));
`else
      chk("txn_count_tied", 32'(bus.txn_count), 0);
      chk("timeout_count_tied", 32'(bus.timeout_count), 0);
`endif
      if (!bus.busy)
        chk("idle_outs", {bus.out_valid, bus.write_en, bus.read_en, bus.write_address,
                          bus.read_address, bus.write_data}, 0);
      if (bus.in_valid && bus.in_ready) begin
        e.y  = stuck ? 8'h00 : (bus.in_a | bus.in_b);
        e.to = stuck;
        oq.push_back(e);
        wq.push_back({3'd0, bus.in_a});
        wq.push_back({3'd5, bus.in_b});
        acc_cyc = cyc;
        stat_cnt = 0;
      end
      if (bus.write_en && bus.write_rdy) begin
        if (wq.size() == 0) chk("write_unexpected", 1, 0);
        else chk("write_addr_data", {bus.write_address, bus.write_data}, wq.pop_front());
      end
      if (bus.busy && bus.read_address == 3'd2 && bus.read_rdy) begin
        stat_cnt++;
        chk("poll_no_read_en", bus.read_en, 0);
      end
      if (bus.read_en) chk("pop_addr_rdy", {bus.read_address, bus.read_rdy}, {3'd3, 1'b1});
      if (bus.out_valid) begin
        chk("out_in_ready_low", bus.in_ready, 0);
        if (!prev_ov && min_lat) chk("min_latency", cyc - acc_cyc, 5);
        if (prev_ov && !prev_or)
          chk("out_stable", {bus.out_y, bus.out_timeout}, {prev_y, prev_to});
        if (bus.out_ready) begin
          if (oq.size() == 0) chk("out_unexpected", 1, 0);
          else begin
            e = oq.pop_front();
            chk("out_y", bus.out_y, e.y);
            chk("out_timeout", bus.out_timeout, e.to);
            if (e.to) chk("timeout_poll_samples", stat_cnt, 300);
          end
          txn_m++;
          if (bus.out_timeout) to_m++;
        end
      end
      prev_ov = bus.out_valid; prev_or = bus.out_ready;
      prev_y = bus.out_y;      prev_to = bus.out_timeout;
    end
  end

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b);
    bit ok = 0;
    bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge CLK);
      if (bus.in_ready) ok = 1;
      else tick();
    end
    if (!ok) chk("accept_wait", 0, 1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(input int hold, input bit toggle, output logic [7:0] y, output logic t);
    bit got = 0;
    y = 'x; t = 'x;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(negedge CLK);
      if (bus.out_valid) got = 1;
      else begin
        tick();
        if (toggle) bus.read_rdy = ~bus.read_rdy;
      end
    end
    if (!got) chk("out_wait", 0, 1);
    y = bus.out_y; t = bus.out_timeout;
    for (int i = 0; i < hold; i++) begin
      tick();
      @(negedge CLK);
      chk("hold_valid", bus.out_valid, 1);
      chk("hold_in_ready", bus.in_ready, 0);
    end
    tick(); bus.out_ready = 1'b1;
    tick(); bus.out_ready = 1'b0; bus.read_rdy = 1'b1;
  endtask

  initial begin
    logic [7:0] y;
    logic t;
    bit seen;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0;
    bus.out_ready = 1'b0; bus.write_rdy = 1'b1; bus.read_rdy = 1'b1;

    // Reset state
    @(negedge CLK);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_strobes", {bus.out_valid, bus.write_en, bus.read_en, bus.busy}, 0);
    chk("rst_out", {bus.out_y, bus.out_timeout}, 0);
    tick(); RST = 1'b0;
    @(negedge CLK);
    chk("post_rst_in_ready", bus.in_ready, 1);
    tick();

    // Minimum-latency merge of 0x0F | 0xF0
    min_lat = 1'b1;
    send(8'h0F, 8'hF0);
    wait_out(0, 0, y, t);
    chk("lit_merge_y", y, 8'hFF);
    chk("lit_merge_to", t, 0);
    min_lat = 1'b0;

    // write_rdy held low for 3 cycles in WR_A
    bus.write_rdy = 1'b0;
    send(8'h12, 8'h40);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("stall_write_en", bus.write_en, 1);
      chk("stall_addr", bus.write_address, 3'd0);
      chk("stall_data", bus.write_data, 8'h12);
      tick();
    end
    bus.write_rdy = 1'b1;
    wait_out(0, 0, y, t);
    chk("lit_stall_y", y, 8'h52);

    // out_ready low 4 cycles, then back-to-back all-zero pair
    send(8'h81, 8'h04);
    wait_out(4, 0, y, t);
    chk("lit_hold_y", y, 8'h85);
    send(8'h00, 8'h00);
    wait_out(0, 0, y, t);
    chk("lit_zero_y", {y, t}, 0);

    // Reset while polling a stuck status
    stuck = 1'b1;
    send(8'h77, 8'h11);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge CLK);
      if (bus.busy && bus.read_address == 3'd2) seen = 1;
      tick();
    end
    chk("reached_poll", seen, 1);
    tick(); tick();
    RST = 1'b1;
    @(negedge CLK);
    chk("midrst_busy", {bus.busy, bus.out_valid, bus.write_en, bus.read_en, bus.in_ready}, 0);
    chk("midrst_poll_cnt", 32'(dut.poll_cnt_q), 0);
    tick(); RST = 1'b0;
    @(negedge CLK);
    chk("after_rst_idle", {bus.busy, bus.in_ready}, 2'b01);
    chk("after_rst_poll_cnt", 32'(dut.poll_cnt_q), 0);
    tick();

    // Three transactions, the middle one timing out with read_rdy toggling
    stuck = 1'b0;
    send(8'hA5, 8'h5A);
    wait_out(0, 0, y, t);
    chk("lit_t1_y", y, 8'hFF);
    stuck = 1'b1;
    send(8'h3C, 8'hC3);
    wait_out(1, 1, y, t);
    chk("lit_to_y", y, 8'h00);
    chk("lit_to_flag", t, 1);
    stuck = 1'b0;
    send(8'h01, 8'h80);
    wait_out(0, 0, y, t);
    chk("lit_t3_y", {y, t}, {8'h81, 1'b0});
    tick();
    @(negedge CLK);
`ifdef DUT_TXN_MASTER_STATS_EN
    chk("lit_txn_count", 32'(bus.txn_count), 3);
    chk("lit_timeout_count", 32'(bus.timeout_count), 1);
`else
    chk("lit_counts_tied", {bus.txn_count, bus.timeout_count}, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errs);
    $fatal(1, "watchdog");
  end
endmodule
